// File: rtl/bram_piece_responder.sv
// Dual-port piece memory: port A serves the wide-word wrapper with a two-stage read,
// port B is the host load/dump path, which the zero sweep also uses.
// state | meaning
// IDLE  | port B serves host reads and writes
// CLEAR | port B writes zero to mem[sweep_cnt]; host accesses are ignored
module bram_piece_responder #(
    parameter  int ADDRS      = 1024,
    parameter  int BRAM_WIDTH = 64,
    parameter  int PIECES     = 32,
    localparam int DEPTH      = ADDRS * PIECES,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [AW-1:0]         bram_addr,
    input  logic                  bram_we,
    input  logic                  bram_regce,
    input  logic [BRAM_WIDTH-1:0] bram_din,
    output logic [BRAM_WIDTH-1:0] bram_dout,
    input  logic [AW-1:0]         host_addr,
    input  logic                  host_we,
    input  logic                  host_re,
    input  logic [BRAM_WIDTH-1:0] host_din,
    output logic [BRAM_WIDTH-1:0] host_dout,
    output logic                  host_valid,
    output logic                  host_collision,
    input  logic                  clear_in,
    output logic                  busy_out
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state;
    logic [AW-1:0]           sweep_cnt;
    logic [BRAM_WIDTH-1:0]   mem [DEPTH];

    logic [BRAM_WIDTH-1:0]   a_stage;
    logic [BRAM_WIDTH-1:0]   b_stage;
    logic                    b_stage_vld;

    logic                    a_ok;
    logic                    a_wr;
    logic [BRAM_WIDTH-1:0]   a_rd;
    logic                    b_rd_ok;
    logic [BRAM_WIDTH-1:0]   b_rd;
    logic                    b_wr_en;
    logic [AW-1:0]           b_wr_addr;
    logic [BRAM_WIDTH-1:0]   b_wr_data;
    logic                    b_wr_go;
    logic                    collision;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return int'(addr) < DEPTH;
    endfunction

    assign a_ok    = in_range(bram_addr);
    assign a_wr    = bram_we && a_ok;
    assign a_rd    = a_ok ? mem[bram_addr] : '0;
    assign b_rd_ok = in_range(host_addr);
    assign b_rd    = b_rd_ok ? mem[host_addr] : '0;

    // The sweep borrows port B's write path; port A is never stalled.
    always_comb begin
        b_wr_en   = 1'b0;
        b_wr_addr = host_addr;
        b_wr_data = host_din;
        if (state == CLEAR) begin
            b_wr_en   = 1'b1;
            b_wr_addr = sweep_cnt;
            b_wr_data = '0;
        end else if (host_we) begin
            b_wr_en   = 1'b1;
        end
    end

    // Port A wins a same-address write; only a dropped host write is flagged.
    assign b_wr_go   = b_wr_en && in_range(b_wr_addr) && !(a_wr && (bram_addr == b_wr_addr));
    assign collision = (state == IDLE) && host_we && a_wr && (bram_addr == host_addr);

    always_ff @(posedge clk_in) begin
        if (b_wr_go) begin
            mem[b_wr_addr] <= b_wr_data;
        end
        if (a_wr) begin
            mem[bram_addr] <= bram_din;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            sweep_cnt      <= '0;
            busy_out       <= 1'b0;
            a_stage        <= '0;
            bram_dout      <= '0;
            b_stage        <= '0;
            b_stage_vld    <= 1'b0;
            host_dout      <= '0;
            host_valid     <= 1'b0;
            host_collision <= 1'b0;
        end else begin
            a_stage <= a_rd;
            if (bram_regce) begin
                bram_dout <= a_stage;
            end

            b_stage        <= b_rd;
            b_stage_vld    <= host_re && (state == IDLE);
            host_valid     <= b_stage_vld;
            if (b_stage_vld) begin
                host_dout <= b_stage;
            end
            host_collision <= collision;

            case (state)
                IDLE: begin
                    if (clear_in) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                        busy_out  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (sweep_cnt == AW'(DEPTH - 1)) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_piece_responder.sv
// Directed bench for bram_piece_responder with a DEPTH=8, 8-bit configuration.
module tb_bram_piece_responder;

    localparam int ADDRS  = 4;
    localparam int BW     = 8;
    localparam int PIECES = 2;
    localparam int AW     = 3;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic          bram_regce;
    logic [BW-1:0] bram_din;
    logic [BW-1:0] bram_dout;
    logic [AW-1:0] host_addr;
    logic          host_we;
    logic          host_re;
    logic [BW-1:0] host_din;
    logic [BW-1:0] host_dout;
    logic          host_valid;
    logic          host_collision;
    logic          clear_in;
    logic          busy_out;

    int checks   = 0;
    int failures = 0;

    bram_piece_responder #(.ADDRS(ADDRS), .BRAM_WIDTH(BW), .PIECES(PIECES)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .bram_addr      (bram_addr),
        .bram_we        (bram_we),
        .bram_regce     (bram_regce),
        .bram_din       (bram_din),
        .bram_dout      (bram_dout),
        .host_addr      (host_addr),
        .host_we        (host_we),
        .host_re        (host_re),
        .host_din       (host_din),
        .host_dout      (host_dout),
        .host_valid     (host_valid),
        .host_collision (host_collision),
        .clear_in       (clear_in),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        host_we   = 1'b1;
        host_addr = a;
        host_din  = d;
        tick;
        host_we   = 1'b0;
    endtask

    // Reads addresses 0..7 back to back; request i is sampled on one edge and
    // must be reported on the next one.
    task automatic read_burst(input string tag, input logic [7:0] exp [8]);
        host_re   = 1'b1;
        host_addr = 3'd0;
        tick;
        check($sformatf("%s_v_first", tag), {7'b0, host_valid}, 8'h00);
        for (int i = 1; i <= 9; i++) begin
            if (i < 8) begin
                host_re   = 1'b1;
                host_addr = 3'(i);
            end else begin
                host_re   = 1'b0;
            end
            tick;
            if (i <= 8) begin
                check($sformatf("%s_v%0d", tag, i - 1), {7'b0, host_valid}, 8'h01);
                check($sformatf("%s_d%0d", tag, i - 1), host_dout, exp[i - 1]);
            end else begin
                check($sformatf("%s_v_after", tag), {7'b0, host_valid}, 8'h00);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat [8];

        rst_in     = 1'b1;
        bram_addr  = '0;
        bram_we    = 1'b0;
        bram_regce = 1'b0;
        bram_din   = '0;
        host_addr  = '0;
        host_we    = 1'b0;
        host_re    = 1'b0;
        host_din   = '0;
        clear_in   = 1'b0;
        tick;
        tick;
        check("rst_bram_dout", bram_dout, 8'h00);
        check("rst_host_dout", host_dout, 8'h00);
        check("rst_host_valid", {7'b0, host_valid}, 8'h00);
        check("rst_collision", {7'b0, host_collision}, 8'h00);
        check("rst_busy", {7'b0, busy_out}, 8'h00);
        rst_in = 1'b0;
        tick;

        for (int i = 0; i < 8; i++) host_write(3'(i), 8'(8'h11 * (i + 1)));
        pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        read_burst("fill", pat);

        // Port A write, then pipelined read; the write edge captured the old 0x44.
        bram_we   = 1'b1;
        bram_addr = 3'd3;
        bram_din  = 8'hA5;
        tick;
        bram_we    = 1'b0;
        bram_regce = 1'b1;
        tick;
        check("pa_read_first", bram_dout, 8'h44);
        tick;
        check("pa_read", bram_dout, 8'hA5);
        bram_regce = 1'b0;
        bram_addr  = 3'd0;
        tick;
        tick;
        check("pa_hold", bram_dout, 8'hA5);

        bram_we   = 1'b1;
        bram_addr = 3'd5;
        bram_din  = 8'hC3;
        host_we   = 1'b1;
        host_addr = 3'd5;
        host_din  = 8'h3C;
        tick;
        bram_we = 1'b0;
        host_we = 1'b0;
        check("coll_pulse", {7'b0, host_collision}, 8'h01);
        tick;
        check("coll_end", {7'b0, host_collision}, 8'h00);
        host_re   = 1'b1;
        host_addr = 3'd5;
        tick;
        host_re = 1'b0;
        tick;
        check("coll_valid", {7'b0, host_valid}, 8'h01);
        check("coll_data", host_dout, 8'hC3);

        bram_we   = 1'b1;
        bram_addr = 3'd2;
        bram_din  = 8'h77;
        host_re   = 1'b1;
        host_addr = 3'd2;
        tick;
        bram_we = 1'b0;
        host_re = 1'b0;
        tick;
        check("xport_old_valid", {7'b0, host_valid}, 8'h01);
        check("xport_old", host_dout, 8'h33);
        host_re = 1'b1;
        tick;
        host_re = 1'b0;
        tick;
        check("xport_new", host_dout, 8'h77);

        // Full sweep; the early port A write to 7 is zeroed when the sweep reaches 7.
        clear_in = 1'b1;
        tick;
        clear_in = 1'b0;
        check("clr_busy_c0", {7'b0, busy_out}, 8'h01);
        bram_we   = 1'b1;
        bram_addr = 3'd7;
        bram_din  = 8'hEE;
        host_re   = 1'b1;
        host_addr = 3'd1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            bram_we = 1'b0;
            check($sformatf("clr_busy_c%0d", k), {7'b0, busy_out}, (k <= 7) ? 8'h01 : 8'h00);
            check($sformatf("clr_novalid_c%0d", k), {7'b0, host_valid}, 8'h00);
        end
        host_re = 1'b0;
        tick;
        check("clr_novalid_end", {7'b0, host_valid}, 8'h00);
        pat = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        read_burst("clr", pat);

        for (int i = 0; i < 8; i++) host_write(3'(i), 8'(8'h11 * (i + 1)));
        host_re   = 1'b1;
        host_addr = 3'd7;
        tick;
        host_re = 1'b0;
        tick;
        check("refill_d7", host_dout, 8'h88);

        // Abort a sweep after it has zeroed addresses 0..2.
        clear_in = 1'b1;
        tick;
        clear_in  = 1'b0;
        host_re   = 1'b1;
        host_addr = 3'd6;
        tick;
        tick;
        tick;
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_busy", {7'b0, busy_out}, 8'h00);
        check("arst_valid", {7'b0, host_valid}, 8'h00);
        check("arst_host_dout", host_dout, 8'h00);
        check("arst_bram_dout", bram_dout, 8'h00);
        check("arst_collision", {7'b0, host_collision}, 8'h00);
        host_re = 1'b0;
        tick;
        tick;
        check("arst_hold_valid", {7'b0, host_valid}, 8'h00);
        rst_in = 1'b0;
        tick;
        check("arst_post_valid", {7'b0, host_valid}, 8'h00);
        check("arst_post_busy", {7'b0, busy_out}, 8'h00);
        pat = '{8'h00, 8'h00, 8'h00, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        read_burst("abort", pat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
